// File: rtl/sequencia_movimentos.sv
// sequencia_movimentos: steps through a move list held in a synchronous-read
// memory. Each code is issued to the motor controller, and the block then waits
// for mov_done under a timeout. Code 3'b111 ends the list.
// Optional feature: define SEQ_PAUSA_EN to add the pausar input and the PAUSA state.
module sequencia_movimentos #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned TIMEOUT = 50000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [2:0]        dado_mem,
    input  logic              mov_done,
`ifdef SEQ_PAUSA_EN
    input  logic              pausar,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic [2:0]        movimento,
    output logic              mov_start,
    output logic              ocupado,
    output logic              pronto,
    output logic              erro,
    output logic [2:0]        db_estado
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0]  FIM_LISTA = 3'b111;

    typedef enum logic [2:0] {
        StInicial = 3'd0,
        StLe      = 3'd1,
        StEnvia   = 3'd2,
        StAguarda = 3'd3,
        StProximo = 3'd4,
        StFim     = 3'd5,
        StErro    = 3'd6
`ifdef SEQ_PAUSA_EN
        , StPausa = 3'd7
`endif
    } estado_t;

    estado_t           r_estado;
    estado_t           w_prox;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_movimento;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ocupado;
    logic              r_pronto;
    logic              r_erro;
    logic              w_addr_max;
    logic              w_timeout;
    logic              w_emite;

    assign w_addr_max = (r_addr == {ADDR_W{1'b1}});
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
    // The memory word for the current address only becomes valid in ENVIA, so the
    // issue pulse and the code it carries are decoded from that cycle directly.
    assign w_emite    = (r_estado == StEnvia) && (dado_mem != FIM_LISTA);

    assign mov_start  = w_emite;
    assign movimento  = w_emite ? dado_mem : r_movimento;
    assign addr       = r_addr;
    assign ocupado    = r_ocupado;
    assign pronto     = r_pronto;
    assign erro       = r_erro;
    assign db_estado  = r_estado;

    // Next-state decode; mov_done and iniciar only matter in the states listed here.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            StInicial: if (iniciar) w_prox = StLe;
            StLe:      w_prox = StEnvia;
            StEnvia:   w_prox = (dado_mem == FIM_LISTA) ? StFim : StAguarda;
            // mov_done wins over an expiring timeout in the same cycle.
            StAguarda: begin
                if (mov_done) begin
                    w_prox = StProximo;
                end else if (w_timeout) begin
                    w_prox = StErro;
                end
            end
            StProximo: begin
                if (w_addr_max) begin
                    w_prox = StFim;
`ifdef SEQ_PAUSA_EN
                end else if (pausar) begin
                    w_prox = StPausa;
`endif
                end else begin
                    w_prox = StLe;
                end
            end
            StFim:     w_prox = StInicial;
            StErro:    if (iniciar) w_prox = StLe;
`ifdef SEQ_PAUSA_EN
            StPausa:   if (!pausar) w_prox = StLe;
`endif
            default:   w_prox = StInicial;
        endcase
    end

    // State, datapath and registered status flags, with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado    <= StInicial;
            r_addr      <= '0;
            r_movimento <= '0;
            r_cnt       <= '0;
            r_ocupado   <= 1'b0;
            r_pronto    <= 1'b0;
            r_erro      <= 1'b0;
        end else begin
            r_estado  <= w_prox;
            r_ocupado <= (w_prox != StInicial) && (w_prox != StFim) && (w_prox != StErro);
            r_pronto  <= (w_prox == StFim);
            r_erro    <= (w_prox == StErro);
            case (r_estado)
                StInicial: r_addr <= '0;
                StEnvia: begin
                    if (w_emite) r_movimento <= dado_mem;
                    r_cnt <= '0;
                end
                StAguarda: r_cnt <= r_cnt + CNT_W'(1);
                // No wrap: the last address exits to FIM with addr unchanged.
                StProximo: if (!w_addr_max) r_addr <= r_addr + ADDR_W'(1);
                StFim:     r_addr <= '0;
                StErro:    if (iniciar) r_addr <= '0;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequencia_movimentos.sv
// Testbench for sequencia_movimentos (ADDR_W=3, TIMEOUT=20) with a small
// synchronous-read move memory. Define SEQ_PAUSA_EN to also exercise the pause path.
module tb_sequencia_movimentos;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned TIMEOUT = 20;

    logic              clock;
    logic              reset;
    logic              iniciar;
    logic [2:0]        dado_mem;
    logic              mov_done;
`ifdef SEQ_PAUSA_EN
    logic              pausar;
`endif
    logic [ADDR_W-1:0] addr;
    logic [2:0]        movimento;
    logic              mov_start;
    logic              ocupado;
    logic              pronto;
    logic              erro;
    logic [2:0]        db_estado;

    logic [2:0] mem [8];

    int n_tests;
    int n_fail;

    sequencia_movimentos #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .dado_mem (dado_mem),
        .mov_done (mov_done),
`ifdef SEQ_PAUSA_EN
        .pausar   (pausar),
`endif
        .addr     (addr),
        .movimento(movimento),
        .mov_start(mov_start),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .erro     (erro),
        .db_estado(db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Move memory: one-cycle synchronous read.
    always @(posedge clock) dado_mem <= mem[addr];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic       iniciar;
        logic       mov_done;
        logic [2:0] db;
        logic [2:0] addr;
        logic       ms;
        logic [2:0] mov;
        logic       ocup;
        logic       pronto;
        logic       erro;
    } vec_t;

    vec_t vt [18];

    function automatic vec_t mk(input logic ini, input logic done, input logic [2:0] db,
                                input logic [2:0] ad, input logic ms, input logic [2:0] mov,
                                input logic ocup, input logic pr, input logic er);
        vec_t v;
        v.iniciar = ini; v.mov_done = done; v.db = db; v.addr = ad; v.ms = ms;
        v.mov = mov; v.ocup = ocup; v.pronto = pr; v.erro = er;
        return v;
    endfunction

    function automatic logic [12:0] outs();
        return {db_estado, addr, mov_start, movimento, ocupado, pronto, erro};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic set_mem(input logic [23:0] words);
        for (int i = 0; i < 8; i++) mem[i] = words[3*i +: 3];
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        iniciar  = 1'b0;
        mov_done = 1'b0;
`ifdef SEQ_PAUSA_EN
        pausar   = 1'b0;
`endif
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget, input string name);
        int k;
        k = 0;
        while (db_estado !== code && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk(name, 32'(db_estado === code), 32'd1);
    endtask

    task automatic pulse_iniciar();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    initial begin
        int n_ms;
        int cyc;
        logic seen_pronto;
        logic [12:0] exp_v;

        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 8; i++) mem[i] = 3'd0;

        // Scenario 1: {2,5,7} stepped cycle by cycle from a table.
        // Packed as word7..word0.
        set_mem({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2});
        //         ini done db ad ms mov oc pr er
        vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 1, 0, 0, 0, 1, 0, 0);
        vt[2]  = mk(0, 0, 2, 0, 1, 2, 1, 0, 0);
        vt[3]  = mk(0, 0, 3, 0, 0, 2, 1, 0, 0);
        vt[4]  = mk(0, 0, 3, 0, 0, 2, 1, 0, 0);
        vt[5]  = mk(0, 1, 3, 0, 0, 2, 1, 0, 0);
        vt[6]  = mk(0, 0, 4, 0, 0, 2, 1, 0, 0);
        vt[7]  = mk(0, 1, 1, 1, 0, 2, 1, 0, 0);
        vt[8]  = mk(0, 0, 2, 1, 1, 5, 1, 0, 0);
        vt[9]  = mk(1, 0, 3, 1, 0, 5, 1, 0, 0);
        vt[10] = mk(0, 0, 3, 1, 0, 5, 1, 0, 0);
        vt[11] = mk(0, 1, 3, 1, 0, 5, 1, 0, 0);
        vt[12] = mk(0, 0, 4, 1, 0, 5, 1, 0, 0);
        vt[13] = mk(0, 0, 1, 2, 0, 5, 1, 0, 0);
        vt[14] = mk(0, 0, 2, 2, 0, 5, 1, 0, 0);
        vt[15] = mk(0, 0, 5, 2, 0, 5, 0, 1, 0);
        vt[16] = mk(0, 1, 0, 0, 0, 5, 0, 0, 0);
        vt[17] = mk(0, 0, 0, 0, 0, 5, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            exp_v = {vt[i].db, vt[i].addr, vt[i].ms, vt[i].mov, vt[i].ocup, vt[i].pronto,
                     vt[i].erro};
            chk($sformatf("seq_table[%0d]", i), 32'(outs()), 32'(exp_v));
            iniciar  = vt[i].iniciar;
            mov_done = vt[i].mov_done;
        end

        // Scenario 2: mov_done never comes -> ERRO exactly 20 cycles into AGUARDA.
        set_mem({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1});
        do_reset();
        @(negedge clock);
        pulse_iniciar();
        wait_state(3'd3, 10, "to_enter_aguarda");
        repeat (19) @(negedge clock);
        chk("to_still_aguarda_19", 32'({db_estado, erro}), 32'({3'd3, 1'b0}));
        @(negedge clock);
        chk("to_erro_at_20", 32'({db_estado, erro, ocupado, addr, movimento}),
            32'({3'd6, 1'b1, 1'b0, 3'd0, 3'd1}));
        mov_done = 1'b1;
        repeat (3) @(negedge clock);
        mov_done = 1'b0;
        chk("to_erro_holds", 32'({db_estado, erro, movimento}), 32'({3'd6, 1'b1, 3'd1}));
        pulse_iniciar();
        chk("to_restart_le", 32'({db_estado, erro, addr, ocupado}),
            32'({3'd1, 1'b0, 3'd0, 1'b1}));
        @(negedge clock);
        chk("to_restart_issue", 32'({db_estado, mov_start, movimento}),
            32'({3'd2, 1'b1, 3'd1}));

        // Scenario 3: 8 non-end codes, iniciar held high throughout; no wrap.
        set_mem({3'd1, 3'd0, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1});
        do_reset();
        @(negedge clock);
        iniciar  = 1'b1;
        mov_done = 1'b1;
        n_ms = 0;
        cyc = 0;
        seen_pronto = 1'b0;
        while (!seen_pronto && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (mov_start) begin
                chk($sformatf("full_issue[%0d]", n_ms),
                    32'({movimento, addr, 8'(cyc)}),
                    32'({mem[n_ms[2:0]], n_ms[2:0], 8'(2 + 4 * n_ms)}));
                n_ms++;
            end
            if (pronto) begin
                seen_pronto = 1'b1;
                chk("full_fim", 32'({addr, db_estado, 8'(cyc)}), 32'({3'd7, 3'd5, 8'd33}));
            end
        end
        chk("full_pronto_seen", 32'(seen_pronto), 32'd1);
        chk("full_issue_count", 32'(n_ms), 32'd8);
        iniciar  = 1'b0;
        mov_done = 1'b0;
        @(negedge clock);
        chk("full_back_inicial", 32'({db_estado, addr, ocupado}), 32'({3'd0, 3'd0, 1'b0}));

        // Scenario 4: reset during AGUARDA of the second move.
        set_mem({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd4, 3'd3});
        @(negedge clock);
        pulse_iniciar();
        wait_state(3'd3, 10, "rst_first_aguarda");
        mov_done = 1'b1;
        @(negedge clock);
        mov_done = 1'b0;
        wait_state(3'd3, 10, "rst_second_aguarda");
        chk("rst_pre_movimento", 32'(movimento), 32'd4);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_all_zero", 32'(outs()), 32'd0);
        reset    = 1'b1;
        mov_done = 1'b1;
        n_ms = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (mov_start || db_estado != 3'd0) n_ms++;
        end
        mov_done = 1'b0;
        chk("rst_done_ignored", 32'(n_ms), 32'd0);

        // Scenario 5: mov_done in the same cycle the counter reaches 19.
        set_mem({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd6});
        do_reset();
        @(negedge clock);
        pulse_iniciar();
        wait_state(3'd3, 10, "edge_enter_aguarda");
        repeat (19) @(negedge clock);
        chk("edge_at_19", 32'({db_estado, movimento}), 32'({3'd3, 3'd6}));
        mov_done = 1'b1;
        @(negedge clock);
        mov_done = 1'b0;
        chk("edge_proximo", 32'({db_estado, erro}), 32'({3'd4, 1'b0}));
        repeat (3) @(negedge clock);
        chk("edge_fim", 32'({db_estado, pronto, erro, addr, mov_start}),
            32'({3'd5, 1'b1, 1'b0, 3'd1, 1'b0}));

`ifdef SEQ_PAUSA_EN
        // Scenario 6: pause after the first move, hold 10 cycles, then resume.
        set_mem({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2});
        do_reset();
        @(negedge clock);
        pulse_iniciar();
        wait_state(3'd3, 10, "pausa_aguarda");
        pausar   = 1'b1;
        mov_done = 1'b1;
        @(negedge clock);
        mov_done = 1'b0;
        chk("pausa_proximo", 32'(db_estado), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("pausa_hold[%0d]", i), 32'({db_estado, addr, ocupado, mov_start}),
                32'({3'd7, 3'd1, 1'b1, 1'b0}));
        end
        pausar = 1'b0;
        @(negedge clock);
        chk("pausa_resume_le", 32'({db_estado, addr}), 32'({3'd1, 3'd1}));
        @(negedge clock);
        chk("pausa_resume_issue", 32'({mov_start, movimento}), 32'({1'b1, 3'd5}));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
